// File: rtl/sig_trace_writer.sv
// Write side of the signal-trace buffer: two decimated valid/ready sample streams
// arbitrated round-robin into circular windows of the shared sample RAM.
module sig_trace_writer #(
    parameter logic [11:0] CH0_BASE = 12'h559,
    parameter logic [11:0] CH1_BASE = 12'h6AD,
    parameter int          DEPTH    = 320,
    parameter int          DECIM    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        freeze,
    input  logic        s0_valid,
    input  logic [11:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [11:0] s1_data,
    output logic        s1_ready,
    output logic        mem_wEn,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [8:0]  wr_ptr0,
    output logic [8:0]  wr_ptr1
);

    localparam int              DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
    localparam logic [8:0]      PTR_LAST = 9'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR0  = 2'b01,
        ST_WR1  = 2'b10
    } state_t;

    state_t           state_r;
    logic [DEC_W-1:0] dec0_r;
    logic [DEC_W-1:0] dec1_r;
    logic [11:0]      hold0_r;
    logic [11:0]      hold1_r;
    logic             hold0_full_r;
    logic             hold1_full_r;
    logic             rr_last_r;

    logic             acc0_s;
    logic             acc1_s;
    logic             load0_s;
    logic             load1_s;
    logic             grant0_s;
    logic             grant1_s;

    // Write strobe is a pure decode of the state flops (Moore output).
    assign mem_wEn = (state_r != ST_IDLE);

    // Handshake, decimation-slot load and round-robin grant decisions.
    always_comb begin
        s0_ready = !hold0_full_r || freeze;
        s1_ready = !hold1_full_r || freeze;
        acc0_s   = s0_valid && s0_ready;
        acc1_s   = s1_valid && s1_ready;
        load0_s  = acc0_s && (dec0_r == '0) && !freeze;
        load1_s  = acc1_s && (dec1_r == '0) && !freeze;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (hold0_full_r && hold1_full_r) begin
            // rr_last_r names the channel served last; the other one wins a tie.
            if (rr_last_r) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (hold0_full_r) begin
            grant0_s = 1'b1;
        end else if (hold1_full_r) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Decimation counters, hold registers, FSM and registered RAM write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            mem_addr     <= 12'h000;
            mem_data     <= 32'h0000_0000;
            wr_ptr0      <= 9'd0;
            wr_ptr1      <= 9'd0;
            dec0_r       <= '0;
            dec1_r       <= '0;
            hold0_r      <= 12'h000;
            hold1_r      <= 12'h000;
            hold0_full_r <= 1'b0;
            hold1_full_r <= 1'b0;
            rr_last_r    <= 1'b1;
        end else if (clear) begin
            state_r      <= ST_IDLE;
            wr_ptr0      <= 9'd0;
            wr_ptr1      <= 9'd0;
            dec0_r       <= '0;
            dec1_r       <= '0;
            hold0_full_r <= 1'b0;
            hold1_full_r <= 1'b0;
        end else begin
            if (acc0_s) begin
                dec0_r <= (dec0_r == DEC_LAST) ? '0 : dec0_r + 1'b1;
            end
            if (acc1_s) begin
                dec1_r <= (dec1_r == DEC_LAST) ? '0 : dec1_r + 1'b1;
            end
            if (load0_s) begin
                hold0_r      <= s0_data;
                hold0_full_r <= 1'b1;
            end
            if (load1_s) begin
                hold1_r      <= s1_data;
                hold1_full_r <= 1'b1;
            end
            // A granted hold is never loaded on the same edge (ready was low or freeze blocks loads).
            if (grant0_s) begin
                state_r      <= ST_WR0;
                mem_addr     <= CH0_BASE + {3'b000, wr_ptr0};
                mem_data     <= {20'h00000, hold0_r};
                hold0_full_r <= 1'b0;
                wr_ptr0      <= (wr_ptr0 == PTR_LAST) ? 9'd0 : wr_ptr0 + 9'd1;
                rr_last_r    <= 1'b0;
            end else if (grant1_s) begin
                state_r      <= ST_WR1;
                mem_addr     <= CH1_BASE + {3'b000, wr_ptr1};
                mem_data     <= {20'h00000, hold1_r};
                hold1_full_r <= 1'b0;
                wr_ptr1      <= (wr_ptr1 == PTR_LAST) ? 9'd0 : wr_ptr1 + 9'd1;
                rr_last_r    <= 1'b1;
            end else begin
                state_r      <= ST_IDLE;
            end
        end
    end

endmodule
